// File: rtl/dmem_arbiter_if.sv
// Requester-side bundle for one data-memory port: request/address/data in,
// grant and registered read return out. The master drives requests; the arbiter is the slave.
interface dmem_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  gnt;
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port data memory: port 0 has fixed priority,
// port 1 is force-granted after STARVE_LIMIT consecutive denied cycles.
module dmem_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  dmem_arbiter_if.slave         p0_io,
  dmem_arbiter_if.slave         p1_io,
  output logic                  mem_wr_en_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wr_data_o,
  input  logic [DATA_WIDTH-1:0] mem_rd_data_i
);

  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STARVE_LIMIT);

  logic [CntW-1:0] starve_q, starve_d;
  logic            rd_pend_q, rd_pend_d;
  logic            rd_owner_q, rd_owner_d;
  logic            force_p1;
  logic            gnt0, gnt1;
  logic            rv0, rv1;

  // Grant decision; reset dominates any request.
  always_comb begin
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    force_p1 = p1_io.req && (starve_q == CntMax);
    if (!rst_i) begin
      if (force_p1) begin
        gnt1 = 1'b1;
      end else if (p0_io.req) begin
        gnt0 = 1'b1;
      end else if (p1_io.req) begin
        gnt1 = 1'b1;
      end
    end
  end

  always_comb begin
    mem_wr_en_o   = 1'b0;
    mem_addr_o    = '0;
    mem_wr_data_o = '0;
    if (gnt0) begin
      mem_wr_en_o   = p0_io.we;
      mem_addr_o    = p0_io.addr;
      mem_wr_data_o = p0_io.wdata;
    end else if (gnt1) begin
      mem_wr_en_o   = p1_io.we;
      mem_addr_o    = p1_io.addr;
      mem_wr_data_o = p1_io.wdata;
    end
  end

  always_comb begin
    starve_d = '0;
    if (p1_io.req && !gnt1) begin
      starve_d = (starve_q == CntMax) ? starve_q : starve_q + 1'b1;
    end
    rd_pend_d  = (gnt0 && !p0_io.we) || (gnt1 && !p1_io.we);
    rd_owner_d = gnt1 && !p1_io.we;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      starve_q   <= '0;
      rd_pend_q  <= 1'b0;
      rd_owner_q <= 1'b0;
    end else begin
      starve_q   <= starve_d;
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  // Read data from dmem arrives one cycle after the address; route it to the owner only.
  always_comb begin
    rv0 = !rst_i && rd_pend_q && !rd_owner_q;
    rv1 = !rst_i && rd_pend_q && rd_owner_q;
  end

  assign p0_io.gnt    = gnt0;
  assign p1_io.gnt    = gnt1;
  assign p0_io.rvalid = rv0;
  assign p1_io.rvalid = rv1;
  assign p0_io.rdata  = rv0 ? mem_rd_data_i : '0;
  assign p1_io.rdata  = rv1 ? mem_rd_data_i : '0;

endmodule
